// File: rtl/teclas_pkg.sv
// Key-code constants, scanner state encoding and keypad map shared by the
// keypad scanner and the calculator.
package teclas_pkg;

  localparam int unsigned KEY_W = 5;

  typedef logic [KEY_W-1:0] key_t;

  localparam key_t T_0    = 5'd0;
  localparam key_t T_1    = 5'd1;
  localparam key_t T_2    = 5'd2;
  localparam key_t T_3    = 5'd3;
  localparam key_t T_4    = 5'd4;
  localparam key_t T_5    = 5'd5;
  localparam key_t T_6    = 5'd6;
  localparam key_t T_7    = 5'd7;
  localparam key_t T_8    = 5'd8;
  localparam key_t T_9    = 5'd9;
  localparam key_t T_A    = 5'd10;
  localparam key_t T_B    = 5'd11;
  localparam key_t T_C    = 5'd12;
  localparam key_t T_D    = 5'd13;
  localparam key_t T_ASTE = 5'd14;
  localparam key_t T_HASH = 5'd15;
  localparam key_t T_NULL = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_HELD
  } scan_state_e;

  // Result of one full scan: single is set only when exactly one key is down.
  typedef struct packed {
    logic single;
    key_t code;
  } scan_res_t;

  // Physical key at snapshot index {row, col}.
  function automatic key_t key_at(input logic [3:0] idx);
    key_t k;
    case (idx)
      4'd0:    k = T_1;
      4'd1:    k = T_2;
      4'd2:    k = T_3;
      4'd3:    k = T_A;
      4'd4:    k = T_4;
      4'd5:    k = T_5;
      4'd6:    k = T_6;
      4'd7:    k = T_B;
      4'd8:    k = T_7;
      4'd9:    k = T_8;
      4'd10:   k = T_9;
      4'd11:   k = T_C;
      4'd12:   k = T_ASTE;
      4'd13:   k = T_0;
      4'd14:   k = T_HASH;
      default: k = T_D;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
module keypad_sync #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  // Idle rows read high through the pull-ups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with debounce; one key pulse per accepted press.
// Define KEYPAD_REPEAT_EN to add auto-repeat pulses while a key is held.
module keypad_scanner
  import teclas_pkg::*;
#(
  parameter int unsigned SCAN_TICKS     = 4,
  parameter int unsigned DEBOUNCE_SCANS = 2
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY   = 500,
  parameter int unsigned REPEAT_PERIOD  = 150
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [4:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned TICK_W = $clog2(SCAN_TICKS);
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_SCANS + 1);

  logic [3:0]        row_sync;
  logic [TICK_W-1:0] tick_q;
  logic [1:0]        col_q;
  logic [3:0]        col_n_q;
  logic [15:0]       snap_q, snap_d;
  logic              last_tick, scan_done;
  scan_res_t         res;

  scan_state_e       state_q, state_d;
  key_t              cand_q, cand_d, key_q, key_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              valid_q, valid_d, held_q, held_d, emit_c;

  keypad_sync #(.W(4)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (row_n),
    .q_o   (row_sync)
  );

  // 0 keys or several keys both collapse to T_NULL with single cleared.
  function automatic scan_res_t encode(input logic [15:0] snap);
    scan_res_t   r;
    int unsigned n;
    r = '{single: 1'b0, code: T_NULL};
    n = 0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (snap[i]) begin
        n++;
        r.code = key_at(4'(i));
      end
    end
    if (n == 1) r.single = 1'b1;
    else        r.code   = T_NULL;
    return r;
  endfunction

  assign last_tick = (tick_q == TICK_W'(SCAN_TICKS - 1));
  assign scan_done = last_tick && (col_q == 2'd3);

  // Snapshot bit {row, col} is 1 when that key reads as pressed.
  always_comb begin
    snap_d = snap_q;
    if (last_tick) begin
      for (int unsigned r = 0; r < 4; r++) snap_d[{2'(r), col_q}] = ~row_sync[r];
    end
  end

  assign res = encode(snap_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q  <= '0;
      col_q   <= '0;
      col_n_q <= 4'b1110;
      snap_q  <= '0;
    end else begin
      snap_q <= snap_d;
      if (last_tick) begin
        tick_q  <= '0;
        col_q   <= col_q + 2'd1;
        col_n_q <= ~(4'b0001 << (col_q + 2'd1));
      end else begin
        tick_q <= tick_q + TICK_W'(1);
      end
    end
  end

  assign cnt_inc = (cnt_q == CNT_W'(DEBOUNCE_SCANS)) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_DELAY);
  logic [REP_W-1:0] rep_q, rep_d;
`endif

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    key_d   = T_NULL;
    valid_d = 1'b0;
    held_d  = held_q;
    emit_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (scan_done && res.single) begin
          cand_d  = res.code;
          cnt_d   = CNT_W'(1);
          state_d = S_DEBOUNCE;
          if (DEBOUNCE_SCANS == 1) emit_c = 1'b1;
        end
      end
      S_DEBOUNCE: begin
        if (scan_done) begin
          if (!res.single) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (res.code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) emit_c = 1'b1;
          end else begin
            cand_d = res.code;
            cnt_d  = CNT_W'(1);
          end
        end
      end
      S_HELD: begin
        // Anything other than the held key alone counts towards release.
        if (scan_done) begin
          if (res.single && (res.code == cand_q)) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
              cnt_d   = '0;
              held_d  = 1'b0;
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (emit_c) begin
      key_d   = cand_d;
      valid_d = 1'b1;
      held_d  = 1'b1;
      cnt_d   = '0;
      state_d = S_HELD;
    end
`ifdef KEYPAD_REPEAT_EN
    // Reload keeps the period without a second counter; assumes PERIOD <= DELAY.
    rep_d = '0;
    if ((state_q == S_HELD) && (state_d == S_HELD)) begin
      if (rep_q == REP_W'(REPEAT_DELAY - 1)) begin
        rep_d   = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);
        key_d   = cand_q;
        valid_d = 1'b1;
      end else begin
        rep_d = rep_q + REP_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cand_q  <= T_NULL;
      cnt_q   <= '0;
      key_q   <= T_NULL;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      held_q  <= held_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign col_n     = col_n_q;
  assign key       = key_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule
